// File: rtl/centroid_tracker_pkg.sv
// Shared types and constants for the centroid tracker.
// State encoding, screen geometry and a per-axis distance test.
package centroid_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    COAST   = 2'd3
  } state_t;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int DEF_FRAC  = 4;
  localparam int DEF_SHIFT = 2;

  function automatic logic near(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [16:0] lim
  );
    logic [15:0] d;
    d = (a > b) ? a - b : b - a;
    return {1'b0, d} <= lim;
  endfunction

endpackage

// File: rtl/centroid_tracker_if.sv
// Control/status bundle between the tracker FSM and one filter axis.
// PW is the width of the clamped pixel position on that axis.
interface centroid_tracker_if #(
  parameter int PW = 10
);
  logic [15:0]       sample;
  logic              step;
  logic              load;
  logic              update;
  logic [PW-1:0]     pos;
  logic              near;
  logic signed [10:0] vel;

  modport master (
    output sample, step, load, update,
    input  pos, near, vel
  );

  modport slave (
    input  sample, step, load, update,
    output pos, near, vel
  );
endinterface

// File: rtl/centroid_ema_axis.sv
// One axis of the tracker: fixed-point EMA accumulator, clamp, jump test.
// Velocity register exists only when VELOCITY_EN is defined.
module centroid_ema_axis
  import centroid_tracker_pkg::*;
#(
  parameter int LIMIT    = SCREEN_W,
  parameter int SHIFT    = DEF_SHIFT,
  parameter int FRAC     = DEF_FRAC,
  parameter int JUMP_MAX = 64,
  parameter int PW       = 10
) (
  input  logic clk,
  input  logic rst,
  centroid_tracker_if.slave bus
);

  localparam int AW = FRAC + 11;
  localparam logic [10:0] LIM = 11'(LIMIT - 1);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] s_fx;
  logic signed [AW-1:0] diff;
  logic signed [AW-1:0] acc_next;
  logic [10:0]          cur_int;

  function automatic logic [PW-1:0] clamp(
    input logic [10:0] v
  );
    return (v > LIM) ? PW'(LIM) : v[PW-1:0];
  endfunction

  // Only in-range samples are ever loaded, so 10 bits suffice.
  assign s_fx     = $signed(AW'(bus.sample[9:0])) <<< FRAC;
  assign diff     = s_fx - acc;
  assign acc_next = acc + (diff >>> SHIFT);
  assign cur_int  = acc[AW-1:FRAC];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (bus.step && bus.load) begin
      acc <= s_fx;
    end else if (bus.step && bus.update) begin
      acc <= acc_next;
    end
  end

  assign bus.pos  = clamp(cur_int);
  assign bus.near = near(bus.sample, 16'(cur_int),
                         17'(JUMP_MAX));

`ifdef VELOCITY_EN
  logic [10:0]        nxt_int;
  logic signed [PW:0] dv;
  logic signed [10:0] dv_ext;
  logic signed [10:0] vel;

  assign nxt_int = acc_next[AW-1:FRAC];
  assign dv      = $signed({1'b0, clamp(nxt_int)})
                 - $signed({1'b0, clamp(cur_int)});
  assign dv_ext  = dv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vel <= '0;
    end else if (bus.step) begin
      vel <= bus.update ? dv_ext : '0;
    end
  end

  assign bus.vel = vel;
`else
  assign bus.vel = '0;
`endif

endmodule

// File: rtl/centroid_tracker.sv
// Per-frame ball centre qualifier and smoother (IDLE/ACQUIRE/TRACK/COAST).
// Define VELOCITY_EN to build the per-frame velocity outputs.
module centroid_tracker
  import centroid_tracker_pkg::*;
#(
  parameter int SHIFT       = DEF_SHIFT,
  parameter int FRAC        = DEF_FRAC,
  parameter int ACQ_FRAMES  = 3,
  parameter int ACQ_RADIUS  = 16,
  parameter int JUMP_MAX    = 64,
  parameter int LOST_FRAMES = 8
) (
  input  logic               iVgaClk,
  input  logic               reset,
  input  logic               iVgaVRequest,
  input  logic [15:0]        iRedPixelHIndex,
  input  logic [15:0]        iRedPixelVIndex,
  output logic [8:0]         oTrackRow,
  output logic [9:0]         oTrackCol,
  output logic               oLocked,
  output logic [1:0]         oState,
  output logic               oFrameValid,
  output logic signed [10:0] oVelRow,
  output logic signed [10:0] oVelCol
);

  logic        vreq_q;
  logic        eof_d1;
  logic        eof_d2;
  logic        frame_valid;
  logic [15:0] row_q, col_q;
  logic [15:0] cand_row, cand_col;
  logic [15:0] cand_row_n, cand_col_n;
  logic [7:0]  acq_cnt, acq_cnt_n;
  logic [7:0]  miss_cnt, miss_cnt_n;
  state_t      state, state_n;
  logic        load, update;
  logic        in_range, cand_near, accept;

  centroid_tracker_if #(.PW(9))  row_bus ();
  centroid_tracker_if #(.PW(10)) col_bus ();

  centroid_ema_axis #(
    .LIMIT    (SCREEN_H),
    .SHIFT    (SHIFT),
    .FRAC     (FRAC),
    .JUMP_MAX (JUMP_MAX),
    .PW       (9)
  ) u_row (
    .clk (iVgaClk),
    .rst (reset),
    .bus (row_bus)
  );

  centroid_ema_axis #(
    .LIMIT    (SCREEN_W),
    .SHIFT    (SHIFT),
    .FRAC     (FRAC),
    .JUMP_MAX (JUMP_MAX),
    .PW       (10)
  ) u_col (
    .clk (iVgaClk),
    .rst (reset),
    .bus (col_bus)
  );

  assign row_bus.sample = row_q;
  assign col_bus.sample = col_q;
  assign row_bus.step   = eof_d2;
  assign col_bus.step   = eof_d2;
  assign row_bus.load   = load;
  assign col_bus.load   = load;
  assign row_bus.update = update;
  assign col_bus.update = update;

  assign in_range  = (row_q < 16'(SCREEN_H))
                  && (col_q < 16'(SCREEN_W));
  assign cand_near = near(row_q, cand_row, 17'(ACQ_RADIUS))
                  && near(col_q, cand_col, 17'(ACQ_RADIUS));
  assign accept    = in_range && row_bus.near && col_bus.near;

  // EOF at edge E; inputs captured at E+1; state updates at E+2.
  always_ff @(posedge iVgaClk or posedge reset) begin
    if (reset) begin
      vreq_q      <= 1'b0;
      eof_d1      <= 1'b0;
      eof_d2      <= 1'b0;
      frame_valid <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      state       <= IDLE;
      cand_row    <= '0;
      cand_col    <= '0;
      acq_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      vreq_q      <= iVgaVRequest;
      eof_d1      <= vreq_q & ~iVgaVRequest;
      eof_d2      <= eof_d1;
      frame_valid <= eof_d2;
      if (eof_d1) begin
        row_q <= iRedPixelHIndex;
        col_q <= iRedPixelVIndex;
      end
      state    <= state_n;
      cand_row <= cand_row_n;
      cand_col <= cand_col_n;
      acq_cnt  <= acq_cnt_n;
      miss_cnt <= miss_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    cand_row_n = cand_row;
    cand_col_n = cand_col;
    acq_cnt_n  = acq_cnt;
    miss_cnt_n = miss_cnt;
    load       = 1'b0;
    update     = 1'b0;
    if (eof_d2) begin
      unique case (state)
        IDLE: begin
          if (in_range) begin
            cand_row_n = row_q;
            cand_col_n = col_q;
            acq_cnt_n  = 8'd1;
            if (ACQ_FRAMES <= 1) begin
              state_n = TRACK;
              load    = 1'b1;
            end else begin
              state_n = ACQUIRE;
            end
          end
        end
        ACQUIRE: begin
          if (!in_range) begin
            state_n = IDLE;
          end else begin
            cand_row_n = row_q;
            cand_col_n = col_q;
            if (cand_near) begin
              acq_cnt_n = acq_cnt + 8'd1;
              if (acq_cnt + 8'd1 >= 8'(ACQ_FRAMES)) begin
                state_n = TRACK;
                load    = 1'b1;
              end
            end else begin
              acq_cnt_n = 8'd1;
            end
          end
        end
        TRACK: begin
          if (accept) begin
            update = 1'b1;
          end else begin
            state_n    = COAST;
            miss_cnt_n = 8'd1;
          end
        end
        COAST: begin
          if (accept) begin
            update     = 1'b1;
            state_n    = TRACK;
            miss_cnt_n = 8'd0;
          end else begin
            miss_cnt_n = miss_cnt + 8'd1;
            if (miss_cnt + 8'd1 >= 8'(LOST_FRAMES))
              state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign oTrackRow   = row_bus.pos;
  assign oTrackCol   = col_bus.pos;
  assign oLocked     = (state == TRACK) || (state == COAST);
  assign oState      = state;
  assign oFrameValid = frame_valid;
  assign oVelRow     = row_bus.vel;
  assign oVelCol     = col_bus.vel;

endmodule

// File: tb/tb_centroid_tracker.sv
// Directed plus random frames against a frame-level reference model.
module tb_centroid_tracker;

  localparam int FRACM = 16;
  localparam int GAIN  = 4;
  localparam int ACQ   = 3;
  localparam int RAD   = 16;
  localparam int JUMP  = 64;
  localparam int LOST  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vreq = 1'b0;
  logic [15:0] row_in = '0;
  logic [15:0] col_in = '0;
  logic [8:0]  track_row;
  logic [9:0]  track_col;
  logic        locked;
  logic [1:0]  state;
  logic        fv;
  logic signed [10:0] vel_row;
  logic signed [10:0] vel_col;

  always #5 clk = ~clk;

  centroid_tracker dut (
    .iVgaClk         (clk),
    .reset           (rst),
    .iVgaVRequest    (vreq),
    .iRedPixelHIndex (row_in),
    .iRedPixelVIndex (col_in),
    .oTrackRow       (track_row),
    .oTrackCol       (track_col),
    .oLocked         (locked),
    .oState          (state),
    .oFrameValid     (fv),
    .oVelRow         (vel_row),
    .oVelCol         (vel_col)
  );

  int checks = 0;
  int passed = 0;

  // reference model: 0 idle, 1 acquire, 2 track, 3 coast
  int m_state, m_cnt, m_miss;
  int m_cand_r, m_cand_c;
  int m_acc_r, m_acc_c;
  int m_vel_r, m_vel_c;

  function automatic int absd(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int pos_of(int acc, int lim);
    int p;
    p = acc / FRACM;
    return (p > lim - 1) ? lim - 1 : p;
  endfunction

  function automatic int ema(int acc, int s);
    int d, q;
    d = s * FRACM - acc;
    q = d / GAIN;
    if (d < 0 && (d % GAIN) != 0) q = q - 1;
    return acc + q;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_miss = 0;
    m_cand_r = 0; m_cand_c = 0;
    m_acc_r = 0; m_acc_c = 0;
    m_vel_r = 0; m_vel_c = 0;
  endtask

  task automatic model_lock(int r, int c);
    m_acc_r = r * FRACM;
    m_acc_c = c * FRACM;
    m_state = 2;
  endtask

  task automatic model_filter(int r, int c);
    int orow, ocol;
    orow = pos_of(m_acc_r, 480);
    ocol = pos_of(m_acc_c, 640);
    m_acc_r = ema(m_acc_r, r);
    m_acc_c = ema(m_acc_c, c);
    m_vel_r = pos_of(m_acc_r, 480) - orow;
    m_vel_c = pos_of(m_acc_c, 640) - ocol;
  endtask

  task automatic model_step(int r, int c);
    bit inr, ok;
    inr = (r < 480) && (c < 640);
    ok  = inr && absd(r, m_acc_r / FRACM) <= JUMP
              && absd(c, m_acc_c / FRACM) <= JUMP;
    m_vel_r = 0;
    m_vel_c = 0;
    case (m_state)
      0: if (inr) begin
        m_cand_r = r; m_cand_c = c; m_cnt = 1;
        if (m_cnt >= ACQ) model_lock(r, c);
        else m_state = 1;
      end
      1: if (!inr) begin
        m_state = 0;
      end else if (absd(r, m_cand_r) <= RAD &&
                   absd(c, m_cand_c) <= RAD) begin
        m_cand_r = r; m_cand_c = c; m_cnt++;
        if (m_cnt >= ACQ) model_lock(r, c);
      end else begin
        m_cand_r = r; m_cand_c = c; m_cnt = 1;
      end
      2: if (ok) begin
        model_filter(r, c);
      end else begin
        m_state = 3; m_miss = 1;
      end
      default: if (ok) begin
        model_filter(r, c);
        m_state = 2; m_miss = 0;
      end else begin
        m_miss++;
        if (m_miss >= LOST) m_state = 0;
      end
    endcase
  endtask

  task automatic check(string tag,
                       logic signed [31:0] obs,
                       logic signed [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
  endtask

  task automatic check_all(string tag);
    int evr, evc;
`ifdef VELOCITY_EN
    evr = m_vel_r; evc = m_vel_c;
`else
    evr = 0; evc = 0;
`endif
    check({tag, ".state"}, 32'(state), m_state);
    check({tag, ".row"}, 32'(track_row),
          pos_of(m_acc_r, 480));
    check({tag, ".col"}, 32'(track_col),
          pos_of(m_acc_c, 640));
    check({tag, ".locked"}, 32'(locked),
          (m_state >= 2) ? 1 : 0);
    check({tag, ".vel_row"}, 32'(vel_row), evr);
    check({tag, ".vel_col"}, 32'(vel_col), evc);
  endtask

  task automatic frame(string tag, int r, int c);
    row_in = 16'(r);
    col_in = 16'(c);
    vreq = 1'b1;
    repeat (4) @(negedge clk);
    vreq = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 check({tag, ".fv_early"}, 32'(fv), 0);
    @(posedge clk);
    #1 check({tag, ".fv"}, 32'(fv), 1);
    model_step(r, c);
    check_all(tag);
    @(posedge clk);
    #1 check({tag, ".fv_off"}, 32'(fv), 0);
    @(negedge clk);
  endtask

  int base_r, base_c, r, c, mode;
  bit pulse;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset.fv", 32'(fv), 0);
    check_all("reset");

    for (int i = 0; i < 3; i++) frame("acq", 100, 200);
    frame("filt1", 100, 232);
    frame("filt2", 100, 232);
    frame("jump", 100, 400);
    frame("recov", 100, 219);

    for (int i = 0; i < 8; i++) frame("lost", 16'hFFFF, 200);

    frame("rs1", 100, 100);
    frame("rs2", 100, 150);
    frame("rs3", 100, 155);
    frame("rs4", 100, 160);
    frame("edge", 479, 639);
    frame("clampmax", 479, 639);

    vreq = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("midrst.fv", 32'(fv), 0);
    check_all("midrst");
    @(negedge clk);
    vreq = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pulse = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 pulse = pulse | fv;
    end
    check("midrst.no_eof", 32'(pulse), 0);
    @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      mode = int'($urandom_range(0, 9));
      if (m_state >= 2) begin
        base_r = m_acc_r / FRACM;
        base_c = m_acc_c / FRACM;
      end else begin
        base_r = m_cand_r;
        base_c = m_cand_c;
      end
      if (mode == 0) begin
        r = 480 + int'($urandom_range(0, 500));
        c = int'($urandom_range(0, 639));
      end else if (mode == 1) begin
        r = int'($urandom_range(0, 479));
        c = int'($urandom_range(0, 639));
      end else begin
        r = base_r + int'($urandom_range(0, 40)) - 20;
        c = base_c + int'($urandom_range(0, 40)) - 20;
        r = (r < 0) ? 0 : (r > 479) ? 479 : r;
        c = (c < 0) ? 0 : (c > 639) ? 639 : c;
      end
      frame("rand", r, c);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
